// File: rtl/contador_vertical_sync.sv
// Vertical line counter, vertical phase FSM and sync/visible decode for a VGA timing chain.
// Latency 1 from h_value/ativa_v_counter to every output; no backpressure. Optional FRAME_COUNT_EN adds a frame counter.
module contador_vertical_sync #(
   parameter int H_VISIBLE    = 640,
   parameter int H_SYNC_START = 656,
   parameter int H_SYNC_END   = 752,
   parameter int H_TOTAL      = 800,
   parameter int V_VISIBLE    = 480,
   parameter int V_FRONT      = 10,
   parameter int V_SYNC       = 2,
   parameter int V_BACK       = 33
) (
   input  logic        clk_25mhz,
   input  logic        rst,
   input  logic [15:0] h_value,
   input  logic        ativa_v_counter,
   output logic [15:0] v_value,
   output logic        hsync,
   output logic        vsync,
   output logic        video_on,
   output logic [9:0]  pixel_x,
   output logic [9:0]  pixel_y,
   output logic        frame_start,
   output logic [7:0]  frame_count
);

   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   localparam logic [15:0] H_VIS_W      = 16'(H_VISIBLE);
   localparam logic [15:0] H_SS_W       = 16'(H_SYNC_START);
   localparam logic [15:0] H_SE_W       = 16'(H_SYNC_END);
   localparam logic [15:0] H_TOT_W      = 16'(H_TOTAL);
   localparam logic [15:0] V_LAST_ACT   = 16'(V_VISIBLE - 1);
   localparam logic [15:0] V_LAST_FRONT = 16'(V_VISIBLE + V_FRONT - 1);
   localparam logic [15:0] V_LAST_SYNC  = 16'(V_VISIBLE + V_FRONT + V_SYNC - 1);
   localparam logic [15:0] V_LAST       = 16'(V_TOTAL - 1);

   typedef enum logic [1:0] {
      ST_ACTIVE = 2'd0,
      ST_FRONT  = 2'd1,
      ST_SYNC   = 2'd2,
      ST_BACK   = 2'd3
   } vstate_t;

   vstate_t     state;
   vstate_t     state_nxt;
   logic [15:0] line_nxt;
   logic        line_wrap;
   logic        h_in_range;
   logic        h_visible;
   logic        h_sync_zone;
   logic        vis_nxt;

   // The advance pulse is authoritative: the line moves whatever h_value says.
   always_comb begin
      line_nxt  = v_value;
      line_wrap = 1'b0;
      if (ativa_v_counter) begin
         if (v_value >= V_LAST) begin
            line_nxt  = 16'd0;
            line_wrap = 1'b1;
         end else begin
            line_nxt  = v_value + 16'd1;
         end
      end
   end

   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         state <= ST_ACTIVE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      if (ativa_v_counter) begin
         case (state)
            ST_ACTIVE: if (v_value == V_LAST_ACT)   state_nxt = ST_FRONT;
            ST_FRONT:  if (v_value == V_LAST_FRONT) state_nxt = ST_SYNC;
            ST_SYNC:   if (v_value == V_LAST_SYNC)  state_nxt = ST_BACK;
            ST_BACK:   if (line_wrap)               state_nxt = ST_ACTIVE;
            default:                                state_nxt = ST_ACTIVE;
         endcase
      end
   end

   // Out-of-range h_value is blanked with hsync released.
   always_comb begin
      h_in_range  = (h_value < H_TOT_W);
      h_visible   = h_in_range && (h_value < H_VIS_W);
      h_sync_zone = h_in_range && (h_value >= H_SS_W) && (h_value < H_SE_W);
      vis_nxt     = h_visible && (state_nxt == ST_ACTIVE);
   end

   // Outputs pair the sampled h_value with the line it belongs to, i.e. after this cycle's advance.
   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         v_value     <= 16'd0;
         hsync       <= 1'b1;
         vsync       <= 1'b1;
         video_on    <= 1'b0;
         pixel_x     <= 10'd0;
         pixel_y     <= 10'd0;
         frame_start <= 1'b0;
      end else begin
         v_value     <= line_nxt;
         hsync       <= ~h_sync_zone;
         vsync       <= (state_nxt != ST_SYNC);
         video_on    <= vis_nxt;
         pixel_x     <= vis_nxt ? h_value[9:0] : 10'd0;
         pixel_y     <= vis_nxt ? line_nxt[9:0] : 10'd0;
         frame_start <= (h_value == 16'd0) && (line_nxt == 16'd0);
      end
   end

`ifdef FRAME_COUNT_EN
   logic [7:0] frame_cnt_q;

   always_ff @(posedge clk_25mhz) begin
      if (rst) begin
         frame_cnt_q <= 8'd0;
      end else if (line_wrap) begin
         frame_cnt_q <= frame_cnt_q + 8'd1;
      end
   end

   assign frame_count = frame_cnt_q;
`else
   assign frame_count = 8'd0;
`endif

endmodule

// File: tb/tb_contador_vertical_sync.sv
// Scoreboard bench for contador_vertical_sync on a reduced raster so several frames fit a short run.
module tb_contador_vertical_sync;

   localparam int HV  = 40;
   localparam int HSS = 44;
   localparam int HSE = 50;
   localparam int HT  = 56;
   localparam int VV  = 30;
   localparam int VF  = 3;
   localparam int VS  = 2;
   localparam int VB  = 5;
   localparam int VT  = VV + VF + VS + VB;

   logic        clk_25mhz = 1'b0;
   logic        rst = 1'b0;
   logic [15:0] h_value = 16'd0;
   logic        ativa_v_counter = 1'b0;
   logic [15:0] v_value;
   logic        hsync, vsync, video_on, frame_start;
   logic [9:0]  pixel_x, pixel_y;
   logic [7:0]  frame_count;

   contador_vertical_sync #(
      .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_END(HSE), .H_TOTAL(HT),
      .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB)
   ) dut (
      .clk_25mhz(clk_25mhz), .rst(rst), .h_value(h_value),
      .ativa_v_counter(ativa_v_counter), .v_value(v_value),
      .hsync(hsync), .vsync(vsync), .video_on(video_on),
      .pixel_x(pixel_x), .pixel_y(pixel_y),
      .frame_start(frame_start), .frame_count(frame_count)
   );

   always #5 clk_25mhz = ~clk_25mhz;

   typedef struct {
      int v;
      int hs;
      int vs;
      int vid;
      int px;
      int py;
      int fs;
      int fc;
      bit win;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;
   int   win_vid = 0;
   int   win_vsl = 0;
   int   win_fs  = 0;

   // reference state: line number and frame number as plain integers
   int mv = 0;
   int mfc = 0;
   int hc = 0;
   bit seen_wrap = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive(input int h, input bit a, input bit r, input bit w);
      exp_t e;
      @(negedge clk_25mhz);
      rst = r;
      h_value = 16'(h);
      ativa_v_counter = a;
      if (r) begin
         mv = 0;
         mfc = 0;
         e = '{v:0, hs:1, vs:1, vid:0, px:0, py:0, fs:0, fc:0, win:w};
      end else begin
         if (a) begin
            if (mv == VT - 1) begin
               mv = 0;
`ifdef FRAME_COUNT_EN
               mfc = (mfc + 1) % 256;
`endif
            end else begin
               mv = mv + 1;
            end
         end
         e.v   = mv;
         e.hs  = (h >= HSS && h < HSE) ? 0 : 1;
         e.vs  = (mv >= VV + VF && mv < VV + VF + VS) ? 0 : 1;
         e.vid = (h < HV && mv < VV) ? 1 : 0;
         e.px  = e.vid ? h : 0;
         e.py  = e.vid ? mv : 0;
         e.fs  = (h == 0 && mv == 0) ? 1 : 0;
         e.fc  = mfc;
         e.win = w;
      end
      q.push_back(e);
   endtask

   // one cycle of a free-running upstream horizontal counter
   task automatic tick(input bit r, input bit w);
      bit a;
      a = (hc == 0) && seen_wrap;
      drive(hc, a, r, w);
      hc = (hc + 1) % HT;
      seen_wrap = 1'b1;
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk_25mhz);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            chk("v_value", int'(v_value), e.v);
            chk("hsync", int'(hsync), e.hs);
            chk("vsync", int'(vsync), e.vs);
            chk("video_on", int'(video_on), e.vid);
            chk("pixel_x", int'(pixel_x), e.px);
            chk("pixel_y", int'(pixel_y), e.py);
            chk("frame_start", int'(frame_start), e.fs);
            chk("frame_count", int'(frame_count), e.fc);
            if (e.win) begin
               win_vid += int'(video_on);
               win_vsl += int'(!vsync);
               win_fs  += int'(frame_start);
            end
         end
      end
   end

   initial begin : stim
      int guard;
      // reset, upstream counter restarted at h=0 with no wrap yet
      hc = 0;
      seen_wrap = 1'b0;
      repeat (3) drive(0, 1'b0, 1'b1, 1'b0);
      // exactly one frame counted, then two more frames through the wrap
      for (int i = 0; i < VT * HT; i++) tick(1'b0, 1'b1);
      for (int i = 0; i < 2 * VT * HT; i++) tick(1'b0, 1'b0);
      // reset mid-frame at line 20, h=25; upstream counter keeps running
      guard = 0;
      while (!(mv == 20 && hc == 25) && guard < 4 * VT * HT) begin
         tick(1'b0, 1'b0);
         guard++;
      end
      chk("reach_line20", mv * 1000 + hc, 20 * 1000 + 25);
      tick(1'b1, 1'b0);
      for (int i = 0; i < 3 * HT; i++) tick(1'b0, 1'b0);
      // out-of-range h for three cycles mid-line in the visible area
      guard = 0;
      while (!(mv < VV && hc == 10) && guard < 2 * VT * HT) begin
         tick(1'b0, 1'b0);
         guard++;
      end
      repeat (3) drive(900, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 2 * HT; i++) tick(1'b0, 1'b0);
      // randomized traffic: stray resets, out-of-range values, spurious advance pulses
      for (int i = 0; i < 9000; i++) begin
         int sel;
         sel = $urandom_range(999);
         if (sel < 2) begin
            tick(1'b1, 1'b0);
         end else if (sel < 12) begin
            drive($urandom_range(65535, HT), 1'b0, 1'b0, 1'b0);
         end else if (sel < 17) begin
            drive($urandom_range(HT - 1, 1), 1'b1, 1'b0, 1'b0);
            hc = (hc + 1) % HT;
         end else begin
            tick(1'b0, 1'b0);
         end
      end
      guard = 0;
      while (q.size() > 0 && guard < 10) begin
         @(posedge clk_25mhz);
         guard++;
      end
      #2;
      chk("scoreboard_drained", q.size(), 0);
      chk("frame_video_on_cycles", win_vid, VV * HV);
      chk("frame_vsync_low_cycles", win_vsl, VS * HT);
      chk("frame_start_pulses", win_fs, 1);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/contador_vertical_sync.md
CONTADOR_VERTICAL_SYNC -- requirements
Module: contador_vertical_sync

Interface
REQ-001 The block SHALL have parameter H_VISIBLE, default 640, meaning visible pixels per line.
REQ-002 The block SHALL have parameter H_SYNC_START, default 656, meaning the first h_value with hsync asserted.
REQ-003 The block SHALL have parameter H_SYNC_END, default 752, meaning the first h_value after hsync.
REQ-004 The block SHALL have parameters V_VISIBLE 480, V_FRONT 10, V_SYNC 2 and V_BACK 33, meaning line counts per vertical phase (total 525).
REQ-005 The block SHALL have port clk_25mhz, input, 1 bit: pixel clock, the only clock.
REQ-006 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 The block SHALL have port h_value, input, 16 bits: upstream horizontal count, 0..799.
REQ-008 The block SHALL have port ativa_v_counter, input, 1 bit: line-advance pulse, high in the cycle where h_value==0 after a wrap.
REQ-009 The block SHALL have port v_value, output, 16 bits: current line, 0..524.
REQ-010 The block SHALL have ports hsync and vsync, outputs, 1 bit each: active-low syncs.
REQ-011 The block SHALL have port video_on, output, 1 bit: high in the visible region.
REQ-012 The block SHALL have ports pixel_x and pixel_y, outputs, 10 bits each: visible coordinates, 0 while blanked.
REQ-013 The block SHALL have port frame_start, output, 1 bit: one-cycle pulse at pixel (0,0).
REQ-014 The block SHALL have port frame_count, output, 8 bits: frame counter (see Configuration).

Function
REQ-015 All outputs SHALL be registered; every output SHALL reflect the input h_value of the previous cycle (latency 1) together with the matching line.
REQ-016 On ativa_v_counter==1, v_value SHALL increment by 1, wrapping from 524 to 0; otherwise it SHALL hold.
REQ-017 A vertical FSM SHALL track V_ACTIVE (0..479), V_FRONT (480..489), V_SYNC (490..491) and V_BACK (492..524), with transitions only on ativa_v_counter, and V_BACK -> V_ACTIVE on the 524->0 wrap.
REQ-018 hsync SHALL be 0 iff the delayed h_value is in H_SYNC_START..H_SYNC_END-1.
REQ-019 vsync SHALL be 0 iff the FSM is in V_SYNC.
REQ-020 video_on SHALL be 1 iff the delayed h_value < H_VISIBLE and the FSM is in V_ACTIVE.
REQ-021 pixel_x and pixel_y SHALL equal the delayed h_value[9:0] and v_value[9:0] when video_on is 1, and SHALL be 0 otherwise.
REQ-022 frame_start SHALL be 1 for exactly one cycle, when the output pixel is h=0, v=0.
REQ-023 If h_value > 799 (out of range), that cycle SHALL give video_on=0 and hsync=1, and v_value SHALL be unaffected unless ativa_v_counter is high.
REQ-024 When ativa_v_counter is high with h_value != 0, v_value SHALL still advance, because the pulse is authoritative.

Reset
REQ-025 While rst=1 at a clock edge: v_value=0, FSM=V_ACTIVE, hsync=1, vsync=1, video_on=0, pixel_x=0, pixel_y=0, frame_start=0 and frame_count=0.
REQ-026 A reset mid-frame SHALL abandon the frame; the first cycle after reset release SHALL treat the current line as line 0.
REQ-027 A rst coinciding with ativa_v_counter SHALL take priority.

Configuration
REQ-028 With FRAME_COUNT_EN defined, frame_count SHALL increment (mod 256) on each 524->0 v_value wrap.
REQ-029 Without FRAME_COUNT_EN, frame_count SHALL be constant 0 and no counter register SHALL exist.

Verification
REQ-030 Reset, then drive a free-running upstream counter: v_value steps 0->1 one cycle after the first ativa_v_counter pulse, and hsync is low for 96 cycles per line starting at output h=656.
REQ-031 A full frame (420000 cycles) SHALL give video_on high for exactly 307200 cycles, vsync low for exactly 1600 cycles (lines 490-491), and one frame_start pulse.
REQ-032 Line 524 to 0 wrap: at output h=0 with v=0, frame_start=1, pixel_x=0 and pixel_y=0; with FRAME_COUNT_EN, frame_count goes 0->1.
REQ-033 Assert rst at line 300, h=400 for 1 cycle: the next cycle shows the outputs at their reset values, and the next ativa_v_counter pulse gives v_value=1.
REQ-034 Force h_value=900 for 3 cycles: video_on=0 and hsync=1 during those cycles, and v_value stays unchanged.
REQ-035 Build without FRAME_COUNT_EN and run 3 frames: frame_count stays 0 throughout.
